// File: rtl/toggle_rx_multi.sv
// toggle_rx_multi: multi-channel receive side of a toggle-synchronisation CDC path.
// Each channel resynchronises an asynchronous toggle line and turns every level
// change into a one-cycle pulse. A saturating pending-event counter with an ack
// handshake and a sticky overflow flag keeps back-to-back events from being lost.

module toggle_rx_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                      rd_clk,
    input  logic                      rd_reset,
    input  logic [CHANNELS-1:0]       tgl_in,
    input  logic [CHANNELS-1:0]       ack_in,
    input  logic [CHANNELS-1:0]       ovf_clr,
    output logic [CHANNELS-1:0]       level_out,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS*CNT_W-1:0] pend_cnt,
    output logic [CHANNELS-1:0]       overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] pulse_q;
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic [CHANNELS-1:0] ev;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    // A change on the last sync stage relative to its delayed copy is one event.
    assign ev = sync_q[SYNC_STAGES-1] ^ prev_q;

    // Synchroniser chain, previous-level register and registered edge pulse.
    always_ff @(posedge rd_clk) begin
        if (!rd_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            sync_q[0] <= tgl_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= ev;
        end
    end

    // Pending counter and overflow next state; an event with a same-cycle ack cancels out.
    always_comb begin
        ovf_d = ovf_q & ~ovf_clr;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ev[i] && !ack_in[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (!ev[i] && ack_in[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Counter and sticky overflow registers; reset discards anything pending.
    always_ff @(posedge rd_clk) begin
        if (!rd_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // Pack the per-channel counters onto the flat output bus and derive pending.
    always_comb begin
        pend_cnt = '0;
        pending  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pend_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
            pending[i]                 = |cnt_q[i];
        end
    end

    assign level_out = sync_q[SYNC_STAGES-1];
    assign pulse_out = pulse_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_rx_multi.sv
// Directed testbench for toggle_rx_multi with 4 channels, 2 sync stages and
// 2-bit counters (saturating at 3). Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, away from the edge.

module tb_toggle_rx_multi;

    logic       rd_clk;
    logic       rd_reset;
    logic [3:0] tgl_in;
    logic [3:0] ack_in;
    logic [3:0] ovf_clr;
    logic [3:0] level_out;
    logic [3:0] pulse_out;
    logic [3:0] pending;
    logic [7:0] pend_cnt;
    logic [3:0] overflow;

    int nChecks;
    int nFails;

    toggle_rx_multi #(
        .CHANNELS   (4),
        .SYNC_STAGES(2),
        .CNT_W      (2)
    ) dut (
        .rd_clk   (rd_clk),
        .rd_reset (rd_reset),
        .tgl_in   (tgl_in),
        .ack_in   (ack_in),
        .ovf_clr  (ovf_clr),
        .level_out(level_out),
        .pulse_out(pulse_out),
        .pending  (pending),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    // Free-running receive clock.
    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive all control inputs at once.
    task automatic applyStimulus(input logic rst, input logic [3:0] tgl, input logic [3:0] ack, input logic [3:0] clr);
        rd_reset = rst;
        tgl_in   = tgl;
        ack_in   = ack;
        ovf_clr  = clr;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    // Advance several clocks.
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Directed sequence following the block's test plan.
    initial begin
        int expCnt [4];
        int expOvf [4];
        nChecks = 0;
        nFails  = 0;
        expCnt  = '{1, 2, 3, 3};
        expOvf  = '{0, 0, 0, 1};

        // Reset held with acks and clears asserted: everything stays at zero.
        applyStimulus(1'b0, 4'h0, 4'hF, 4'hF);
        for (int r = 0; r < 3; r++) begin
            tick();
            checkOutput("rst_level",    level_out, 4'h0);
            checkOutput("rst_pulse",    pulse_out, 4'h0);
            checkOutput("rst_pending",  pending,   4'h0);
            checkOutput("rst_pend_cnt", pend_cnt,  8'h00);
            checkOutput("rst_overflow", overflow,  4'h0);
        end
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0);
        tick();

        // Single rising event on ch0, then consume it with one ack.
        $display("[TB] single event on ch0");
        tgl_in = 4'b0001;
        tick();
        checkOutput("se_level_k",  level_out, 4'h0);
        tick();
        checkOutput("se_level_k1", level_out, 4'b0001);
        checkOutput("se_pulse_k1", pulse_out, 4'h0);
        checkOutput("se_cnt_k1",   pend_cnt,  8'h00);
        tick();
        checkOutput("se_pulse_k2", pulse_out, 4'b0001);
        checkOutput("se_cnt_k2",   pend_cnt,  8'h01);
        checkOutput("se_pend_k2",  pending,   4'b0001);
        tick();
        checkOutput("se_pulse_k3", pulse_out, 4'h0);
        checkOutput("se_cnt_k3",   pend_cnt,  8'h01);
        ack_in = 4'b0001;
        tick();
        ack_in = 4'b0000;
        checkOutput("se_cnt_ack",  pend_cnt,  8'h00);
        checkOutput("se_pend_ack", pending,   4'h0);

        // Bring ch2 high first and drain its count so it can fall later.
        tgl_in = 4'b0101;
        ticks(3);
        checkOutput("prep_ch2_cnt", pend_cnt, 8'h10);
        ack_in = 4'b0100;
        tick();
        ack_in = 4'b0000;
        checkOutput("prep_ch2_ack", pend_cnt, 8'h00);

        // ch2 falls while ch1 rises in the same cycle.
        $display("[TB] falling edge and independence");
        tgl_in = 4'b0011;
        ticks(2);
        checkOutput("fi_level",   level_out, 4'b0011);
        checkOutput("fi_nopulse", pulse_out, 4'h0);
        tick();
        checkOutput("fi_pulse",   pulse_out, 4'b0110);
        checkOutput("fi_cnt",     pend_cnt,  8'h14);
        checkOutput("fi_pending", pending,   4'b0110);
        tick();
        checkOutput("fi_pulse_off", pulse_out, 4'h0);
        ack_in = 4'b0110;
        tick();
        ack_in = 4'b0000;
        checkOutput("fi_cnt_ack", pend_cnt, 8'h00);

        // Four ch3 toggles two cycles apart saturate the counter and set overflow.
        $display("[TB] saturation and overflow on ch3");
        for (int i = 0; i < 4; i++) begin
            tgl_in[3] = ~tgl_in[3];
            tick();
            if (i > 0) begin
                checkOutput($sformatf("sat_pulse%0d", i-1), pulse_out[3],         1'b1);
                checkOutput($sformatf("sat_cnt%0d", i-1),   pend_cnt[7:6],        expCnt[i-1]);
                checkOutput($sformatf("sat_ovf%0d", i-1),   overflow[3],          expOvf[i-1]);
            end
            tick();
            checkOutput($sformatf("sat_gap%0d", i), pulse_out[3], 1'b0);
        end
        tgl_in[3] = ~tgl_in[3];
        tick();
        checkOutput("sat_pulse3", pulse_out[3],  1'b1);
        checkOutput("sat_cnt3",   pend_cnt[7:6], 2'd3);
        checkOutput("sat_ovf3",   overflow,      4'b1000);
        tick();
        ovf_clr = 4'b1000;
        tick();
        ovf_clr = 4'b0000;
        checkOutput("sat_pulse4",   pulse_out[3],  1'b1);
        checkOutput("sat_set_wins", overflow[3],   1'b1);
        checkOutput("sat_cnt4",     pend_cnt[7:6], 2'd3);
        tick();
        checkOutput("sat_sticky", overflow[3], 1'b1);
        ovf_clr = 4'b1000;
        tick();
        ovf_clr = 4'b0000;
        checkOutput("sat_cleared", overflow[3], 1'b0);
        checkOutput("sat_cnt_kept", pend_cnt[7:6], 2'd3);

        // Fill ch0 to 3, then a toggle with a coincident ack leaves it unchanged.
        $display("[TB] simultaneous event and ack on ch0");
        for (int i = 0; i < 3; i++) begin
            tgl_in[0] = ~tgl_in[0];
            ticks(3);
        end
        checkOutput("ea_cnt_full", pend_cnt[1:0], 2'd3);
        tgl_in[0] = ~tgl_in[0];
        ticks(2);
        ack_in = 4'b0001;
        tick();
        checkOutput("ea_pulse", pulse_out[0],  1'b1);
        checkOutput("ea_cnt",   pend_cnt[1:0], 2'd3);
        checkOutput("ea_ovf",   overflow[0],   1'b0);
        ticks(3);
        checkOutput("ea_drained", pend_cnt[1:0], 2'd0);
        tick();
        ack_in = 4'b0000;
        checkOutput("ea_ack_at_zero", pend_cnt[1:0], 2'd0);
        checkOutput("ea_pend_zero",   pending[0],    1'b0);
        checkOutput("ea_ovf_zero",    overflow[0],   1'b0);

        // ch1 at count 2 with another toggle in flight, then a one-cycle reset.
        $display("[TB] reset mid-flight");
        tgl_in[1] = ~tgl_in[1];
        ticks(3);
        tgl_in[1] = ~tgl_in[1];
        ticks(3);
        checkOutput("rm_cnt_before", pend_cnt[3:2], 2'd2);
        tgl_in[1] = ~tgl_in[1];
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0);
        tick();
        rd_reset = 1'b1;
        checkOutput("rm_cnt_reset",   pend_cnt,  8'h00);
        checkOutput("rm_pend_reset",  pending,   4'h0);
        checkOutput("rm_level_reset", level_out, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rm_nopulse%0d", i), pulse_out, 4'h0);
            checkOutput($sformatf("rm_nocnt%0d", i),   pend_cnt,  8'h00);
        end
        tgl_in[1] = 1'b1;
        ticks(3);
        checkOutput("rm_pulse_after", pulse_out, 4'b0010);
        checkOutput("rm_cnt_after",   pend_cnt,  8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
